// File: rtl/trace_pkg.sv
// Shared types and constants for the commit-trace capture path.
package trace_pkg;
  localparam int TRACE_IDX_W   = 9;
  localparam int TRACE_DATA_W  = 32;
  localparam int TRACE_STAMP_W = 16;
  localparam int TRACE_HEAD_W  = 2 + TRACE_IDX_W + TRACE_DATA_W;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    REG  = 2'b01,
    MEMW = 2'b10,
    MEMR = 2'b11
  } trace_kind_t;

  typedef struct packed {
    trace_kind_t               kind;
    logic [TRACE_IDX_W-1:0]    index;
    logic [TRACE_DATA_W-1:0]   data;
    logic [TRACE_STAMP_W-1:0]  stamp;
  } trace_entry_t;

  // Stamp-less part of an entry; the stamp width is a parameter of the top.
  function automatic logic [TRACE_HEAD_W-1:0] trace_head(
    input trace_kind_t              kind,
    input logic [TRACE_IDX_W-1:0]   index,
    input logic [TRACE_DATA_W-1:0]  data
  );
    return {kind, index, data};
  endfunction
endpackage

// File: rtl/trace_fifo2w.sv
// Dual-push, single-pop FIFO. push1 is only meaningful together with push0;
// din0 lands first, din1 right behind it.
module trace_fifo2w #(
  parameter int W     = 59,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0,
  input  logic          push1,
  input  logic [W-1:0]  din0,
  input  logic [W-1:0]  din1,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [PW-1:0] level,
  output logic [PW-1:0] free
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_next1;
  logic          do_pop;

  assign wptr_next1 = wptr + PW'(1);
  assign do_pop     = pop && valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + PW'(push0) + PW'(push1);
      rptr <= rptr + PW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push0) mem[wptr[AW-1:0]]       <= din0;
    if (push1) mem[wptr_next1[AW-1:0]] <= din1;
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wptr - rptr;
  assign valid = (level != '0);
  assign free  = PW'(DEPTH) - level;
  assign dout  = valid ? mem[rptr[AW-1:0]] : '0;
endmodule

// File: rtl/commit_trace_buffer.sv
// Samples core write-back / data-memory events each cycle, stamps them and
// queues them for a host-side consumer.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  localparam int PW     = $clog2(DEPTH) + 1,
  localparam int EW     = TRACE_HEAD_W + STAMP_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trace_en,
  input  logic          RegWriteSignal,
  input  logic [4:0]    RegNum,
  input  logic [31:0]   RegData,
  input  logic          WriteEnable,
  input  logic          ReadEnable,
  input  logic [8:0]    Address,
  input  logic [31:0]   WriteData,
  input  logic [31:0]   ReadData,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] out_entry,
  output logic [PW-1:0] level,
  output logic [15:0]   drop_count
);
  // Handshake: the head transfers on a rising edge where out_valid && out_ready;
  // out_entry holds steady while out_valid is high and out_ready is low.
  logic [STAMP_W-1:0] stamp;
  logic               reg_ev;
  logic               mem_ev;
  trace_kind_t        mem_kind;
  logic [EW-1:0]      reg_entry;
  logic [EW-1:0]      mem_entry;
  logic               pop;
  logic [PW-1:0]      free;
  logic [PW:0]        avail;
  logic [1:0]         needed;
  logic               push0;
  logic               push1;
  logic [1:0]         n_drop;
  logic [16:0]        drop_sum;

  assign reg_ev    = trace_en && RegWriteSignal && (RegNum != 5'd0);
  assign mem_ev    = trace_en && (WriteEnable ^ ReadEnable);
  assign mem_kind  = WriteEnable ? MEMW : MEMR;
  assign reg_entry = {trace_head(REG, {4'b0, RegNum}, RegData), stamp};
  assign mem_entry = {trace_head(mem_kind, Address, WriteEnable ? WriteData : ReadData), stamp};

  // A pop in the same cycle frees a slot for an incoming event.
  assign pop    = out_valid && out_ready;
  assign avail  = {1'b0, free} + (PW + 1)'(pop);
  assign needed = {1'b0, reg_ev} + {1'b0, mem_ev};

  // REG has priority, so with one free slot the memory event is the one lost.
  assign push0    = (needed != 2'd0) && (avail != '0);
  assign push1    = (needed == 2'd2) && (avail >= (PW + 1)'(2));
  assign n_drop   = needed - {1'b0, push0} - {1'b0, push1};
  assign drop_sum = {1'b0, drop_count} + 17'(n_drop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp      <= '0;
      drop_count <= '0;
    end else begin
      stamp      <= stamp + STAMP_W'(1);
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  trace_fifo2w #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0),
    .push1 (push1),
    .din0  (reg_ev ? reg_entry : mem_entry),
    .din1  (mem_entry),
    .pop   (pop),
    .dout  (out_entry),
    .valid (out_valid),
    .level (level),
    .free  (free)
  );
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed table, corner sequences and random traffic for commit_trace_buffer,
// checked against a queue-based reference model.
module tb_commit_trace_buffer;
  localparam int DEPTH   = 16;
  localparam int STAMP_W = 16;
  localparam int EW      = 43 + STAMP_W;
  localparam int PW      = 5;

  logic          clk;
  logic          rst;
  logic          trace_en;
  logic          RegWriteSignal;
  logic [4:0]    RegNum;
  logic [31:0]   RegData;
  logic          WriteEnable;
  logic          ReadEnable;
  logic [8:0]    Address;
  logic [31:0]   WriteData;
  logic [31:0]   ReadData;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_entry;
  logic [PW-1:0] level;
  logic [15:0]   drop_count;

  commit_trace_buffer #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .trace_en       (trace_en),
    .RegWriteSignal (RegWriteSignal),
    .RegNum         (RegNum),
    .RegData        (RegData),
    .WriteEnable    (WriteEnable),
    .ReadEnable     (ReadEnable),
    .Address        (Address),
    .WriteData      (WriteData),
    .ReadData       (ReadData),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_entry      (out_entry),
    .level          (level),
    .drop_count     (drop_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int m_drop;
  int m_stamp;
  int n_checks;
  int n_fail;

  function automatic logic [EW-1:0] mk(input logic [1:0] k, input logic [8:0] idx,
                                       input logic [31:0] d, input logic [15:0] s);
    return {k, idx, d, s};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_drop  = 0;
    m_stamp = 0;
  endtask

  // One clock edge of the specified behaviour, from the current inputs.
  task automatic model_edge();
    logic [EW-1:0] ev[$];
    logic [15:0]   s;
    bit            pop;
    int            free;
    s    = m_stamp[15:0];
    pop  = (exp_q.size() > 0) && out_ready;
    free = DEPTH - exp_q.size() + (pop ? 1 : 0);
    if (trace_en) begin
      if (RegWriteSignal && RegNum != 5'd0) ev.push_back(mk(2'b01, {4'b0, RegNum}, RegData, s));
      if (WriteEnable && !ReadEnable)       ev.push_back(mk(2'b10, Address, WriteData, s));
      else if (ReadEnable && !WriteEnable)  ev.push_back(mk(2'b11, Address, ReadData, s));
    end
    if (pop) void'(exp_q.pop_front());
    foreach (ev[i]) begin
      if (i < free) exp_q.push_back(ev[i]);
      else m_drop++;
    end
    if (m_drop > 65535) m_drop = 65535;
    m_stamp = (m_stamp + 1) % 65536;
  endtask

  task automatic compare_model();
    logic [EW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : {EW{1'b0}};
    check("out_valid", out_valid, exp_q.size() > 0);
    check("out_entry", out_entry, head);
    check("level", level, exp_q.size());
    check("drop_count", drop_count, m_drop);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic set_in(input bit en, input bit rw, input logic [4:0] rn, input logic [31:0] rd,
                        input bit we, input bit re, input logic [8:0] a,
                        input logic [31:0] wd, input logic [31:0] rdd, input bit rdy);
    trace_en = en; RegWriteSignal = rw; RegNum = rn; RegData = rd;
    WriteEnable = we; ReadEnable = re; Address = a; WriteData = wd; ReadData = rdd;
    out_ready = rdy;
  endtask

  typedef struct {
    bit            en, rw, we, re, rdy;
    logic [4:0]    rn;
    logic [31:0]   rd, wd, rdd;
    logic [8:0]    a;
    logic          exp_valid;
    logic [EW-1:0] exp_entry;
    logic [PW-1:0] exp_level;
    logic [15:0]   exp_drop;
  } vec_t;

  function automatic vec_t vec(input bit en, input bit rw, input logic [4:0] rn, input logic [31:0] rd,
                               input bit we, input bit re, input logic [8:0] a, input logic [31:0] wd,
                               input logic [31:0] rdd, input bit rdy, input logic ev,
                               input logic [EW-1:0] ee, input logic [PW-1:0] el, input logic [15:0] ed);
    vec_t v;
    v.en = en; v.rw = rw; v.rn = rn; v.rd = rd; v.we = we; v.re = re; v.a = a;
    v.wd = wd; v.rdd = rdd; v.rdy = rdy;
    v.exp_valid = ev; v.exp_entry = ee; v.exp_level = el; v.exp_drop = ed;
    return v;
  endfunction

  vec_t tbl[8];
  logic [EW-1:0] zero_e;
  logic [EW-1:0] e_first;
  logic [EW-1:0] e_reg7;
  logic [EW-1:0] e_memr;
  logic [8:0]    head_idx;
  int            thresh;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    zero_e   = '0;
    model_clear();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_drop", drop_count, 0);
    check("rst_entry", out_entry, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed table: stamps start at 0 on the first edge after reset release.
    e_first = mk(2'b01, 9'd5, 32'hDEADBEEF, 16'd3);
    e_reg7  = mk(2'b01, 9'd7, 32'h10, 16'd4);
    e_memr  = mk(2'b11, 9'h40, 32'h1234, 16'd4);
    tbl[0] = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero_e, 0, 0);
    tbl[1] = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero_e, 0, 0);
    tbl[2] = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero_e, 0, 0);
    tbl[3] = vec(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, e_first, 1, 0);
    tbl[4] = vec(1, 1, 7, 32'h10, 0, 1, 9'h40, 0, 32'h1234, 0, 1, e_first, 3, 0);
    tbl[5] = vec(1, 1, 0, 32'hAAAA, 1, 1, 9'h3, 32'h77, 32'h88, 1, 1, e_reg7, 2, 0);
    tbl[6] = vec(0, 1, 9, 32'h99, 1, 0, 9'h5, 32'h66, 0, 1, 1, e_memr, 1, 0);
    tbl[7] = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, zero_e, 0, 0);
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].en, tbl[i].rw, tbl[i].rn, tbl[i].rd, tbl[i].we, tbl[i].re,
             tbl[i].a, tbl[i].wd, tbl[i].rdd, tbl[i].rdy);
      step();
      check($sformatf("vec%0d_valid", i), out_valid, tbl[i].exp_valid);
      check($sformatf("vec%0d_entry", i), out_entry, tbl[i].exp_entry);
      check($sformatf("vec%0d_level", i), level, tbl[i].exp_level);
      check($sformatf("vec%0d_drop", i), drop_count, tbl[i].exp_drop);
    end

    // Overflow: 15 singles, then a REG+MEMW pair with one slot left.
    for (int i = 0; i < 15; i++) begin
      set_in(1, 0, 0, 0, 1, 0, 9'(i), 32'(i + 100), 0, 0);
      step();
    end
    check("ovf_level15", level, 15);
    set_in(1, 1, 3, 32'h33, 1, 0, 9'h1FF, 32'h44, 0, 0);
    step();
    check("ovf_pair_level", level, 16);
    check("ovf_pair_drop", drop_count, 1);
    set_in(1, 0, 0, 0, 0, 1, 9'h1F0, 0, 32'h55, 0);
    step();
    check("ovf_extra_drop", drop_count, 2);

    // Full FIFO with consumer ready: each pop makes room for the new event.
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 0, 1, 0, 9'(9'h100 + i), 32'(i), 0, 1);
      head_idx = out_entry[STAMP_W+32 +: 9];
      check($sformatf("pop_order%0d", i), head_idx, i);
      step();
    end
    check("full_stream_level", level, 16);
    check("full_stream_drop", drop_count, 2);

    // Drain to 9 and reset between edges.
    for (int i = 0; i < 7; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
    end
    check("pre_reset_level", level, 9);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_level", level, 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_entry", out_entry, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    set_in(1, 1, 1, 32'h55, 0, 0, 0, 0, 0, 0);
    step();
    check("post_rst_entry", out_entry, mk(2'b01, 9'd1, 32'h55, 16'd0));

    // Random traffic with varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      thresh = (i % 600 < 300) ? 30 : 85;
      set_in($urandom_range(0, 9) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 1), $urandom_range(0, 1), 9'($urandom), $urandom, $urandom,
             $urandom_range(0, 99) < thresh);
      step();
    end

    // Drop counter saturation: full FIFO, two events per cycle, no consumer.
    for (int i = 0; i < 32800; i++) begin
      set_in(1, 1, 5'($urandom_range(1, 31)), $urandom, 1, 0, 9'($urandom), $urandom, 0, 0);
      step();
    end
    check("drop_saturated", drop_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Hardware commit-trace capture stage downstream of the `RISCV` core. It samples the core's architectural-event outputs every clock: register write-back, data-memory write and data-memory read. It packs each event into a time-stamped record and queues the records in a dual-push, single-pop FIFO. A host-side consumer (UART bridge or debug port) drains the FIFO over a valid/ready interface, which gives on-chip, non-intrusive visibility of the same events the simulation bench prints.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `STAMP_W`, 16: cycle-stamp width; wraps.
- `clk`  in  1  clock; all sampling on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `trace_en`  in  1  capture enable; 0 = no pushes.
- `RegWriteSignal`  in  1  core register-file write strobe.
- `RegNum`  in  5  destination register.
- `RegData`  in  32  value written.
- `WriteEnable`  in  1  data-memory write strobe.
- `ReadEnable`  in  1  data-memory read strobe.
- `Address`  in  9  data-memory address.
- `WriteData`  in  32  store data.
- `ReadData`  in  32  load data.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head.
- `out_entry`  out  43+STAMP_W  {kind[1:0], index[8:0], data[31:0], stamp}.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `drop_count`  out  16  dropped events; saturates at 0xFFFF.

## Operation
- Event kinds:
  - `REG`=2'b01 when `RegWriteSignal` && `RegNum`≠0. Index = {4'b0, RegNum}. Data = `RegData`.
  - `MEMW`=2'b10 when `WriteEnable` && !`ReadEnable`. Index = `Address`. Data = `WriteData`.
  - `MEMR`=2'b11 when `ReadEnable` && !`WriteEnable`. Index = `Address`. Data = `ReadData`.
  - `WriteEnable` and `ReadEnable` both high: no memory event. Writes to x0 are never traced.
- 0, 1 or 2 events per cycle. Order within a cycle: REG first, then memory event. Both carry the same stamp.
- Stamp counter: 0 at reset, increments every cycle, wraps at 2^STAMP_W. An event captured at an edge carries the pre-increment value.
- Free slots = DEPTH − level + (pop this cycle ? 1 : 0). A same-cycle pop frees a slot for a push.
- Overflow:
  - needed ≤ free: push all events.
  - needed=2, free=1: push REG, drop the memory event.
  - free=0: drop everything.
  - `drop_count` += number dropped, saturating.
- `trace_en`=0: no events, no drops. The stamp keeps counting.
- Pop occurs when `out_valid` && `out_ready`. `out_entry` shows the head combinationally from the array/read pointer and is stable while `out_valid` && !`out_ready`.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. `level` = wptr − rptr.

## Timing
- Reset (async assert, sync deassert at the next edge): `out_valid`=0, `level`=0, `drop_count`=0, stamp=0, pointers=0, `out_entry`=0. Reset mid-operation discards all queued entries immediately.
- Capture latency: an event sampled at edge N appears with `out_valid`=1 after edge N (one cycle) when the FIFO was empty.
- Throughput: 2 pushes + 1 pop per cycle. `level` changes by −1 to +2 per edge.
- `level` and `drop_count` are registered and updated at the same edge as the push/pop.

## Structure
- Package `trace_pkg`:
  - enum `trace_kind_t` (NONE=00, REG, MEMW, MEMR).
  - packed struct `trace_entry_t` {kind, index, data, stamp}.
  - constants `TRACE_IDX_W`=9 and `TRACE_DATA_W`=32.
- Sub-module `trace_fifo2w`: generic dual-push, single-pop FIFO with push0/push1/pop, occupancy and free-count. Drop/priority logic stays in the top.

## Test plan
- After reset, REG event RegNum=5, RegData=0xDEADBEEF at stamp 3 → next cycle `out_valid`=1, entry {01, 5, 0xDEADBEEF, 3}, `level`=1.
- Same edge: REG x7=0x10 and MEMR Address=0x40, ReadData=0x1234 → two entries in order {01,7,0x10,s}, {11,0x40,0x1234,s}, `level`=2.
- `WriteEnable`=`ReadEnable`=1, RegNum=0 write, and `trace_en`=0 with valid events → no entries, `drop_count` unchanged.
- `out_ready`=0, DEPTH=16:
  - 15 single events, then a REG+MEMW pair → REG queued, `level`=16, `drop_count`=1.
  - Then one more event → `drop_count`=2.
- Full FIFO with `out_ready`=1 and one MEMW per cycle for 4 cycles → `level` stays 16, zero drops, and the popped order matches push order.
- `level`=9 mid-stream, assert `rst` between edges → `out_valid`, `level`, `drop_count` go to 0 without waiting for an edge. The first post-reset event carries stamp 0.
